sample_dac_transmitter: RTL and testbench

SAMPLE_DAC_TRANSMITTER -- requirements
Module: SampleDacTransmitter

---
 rtl/sample_dac_transmitter.sv | 123 ++++++++++++
 tb/tb_sample_dac_transmitter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_dac_transmitter.sv
// sample_dac_transmitter: serialises signed 12-bit samples as 16-bit offset-binary DAC frames over an SPI-style link.
// A one-deep holding register decouples the sample strobe from the frame in progress.
module sample_dac_transmitter #(
    parameter int CLOCK_DIV = 2,
    parameter logic [3:0] CONTROL_BITS = 4'b0011
) (
    input  logic        inClock,
    input  logic        inReset,
    input  logic [11:0] inSample,
    input  logic        inSampleReady,
    output logic        outDacSck,
    output logic        outDacMosi,
    output logic        outDacCsN,
    output logic        outBusy,
    output logic        outOverrun
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;
    localparam logic [7:0] LAST  = 8'(CLOCK_DIV - 1);

    logic [1:0]  state, state_n;
    logic [14:0] sh, sh_n;
    logic [7:0]  cnt, cnt_n;
    logic [3:0]  bitn, bitn_n;
    logic [11:0] hold, hold_n;
    logic        pending, pending_n, prev, armed;
    logic        sck, sck_n, mosi, mosi_n, csn, csn_n, busy, busy_n, overrun, overrun_n;
    logic        stb, load, last;
    logic [15:0] frame;

    // armed stays low after reset until the strobe has been seen low once
    assign stb   = inSampleReady & ~prev & armed;
    assign last  = cnt == LAST;
    assign frame = {CONTROL_BITS, ~hold[11], hold[10:0]};

    always_comb begin
        state_n = state;
        sh_n    = sh;
        bitn_n  = bitn;
        sck_n   = sck;
        mosi_n  = mosi;
        csn_n   = csn;
        load    = 1'b0;
        cnt_n   = (state == IDLE || last) ? 8'd0 : cnt + 8'd1;
        case (state)
            IDLE:  load = pending;
            SETUP: begin
                state_n = last ? SHIFT : state;
                sck_n   = last ? 1'b1 : sck;
            end
            SHIFT: begin
                if (last && sck) begin
                    sck_n  = 1'b0;
                    mosi_n = sh[14];
                    sh_n   = {sh[13:0], 1'b0};
                end else if (last && bitn == 4'd15) begin
                    state_n = HOLD;
                    csn_n   = 1'b1;
                    mosi_n  = 1'b0;
                end else if (last) begin
                    sck_n  = 1'b1;
                    bitn_n = bitn + 4'd1;
                end
            end
            default: begin
                load    = last & pending;
                state_n = last ? IDLE : state;
            end
        endcase
        if (load) begin
            state_n = SETUP;
            sh_n    = frame[14:0];
            mosi_n  = frame[15];
            csn_n   = 1'b0;
            cnt_n   = 8'd0;
            bitn_n  = 4'd0;
        end
        pending_n = stb | (pending & ~load);
        overrun_n = stb & pending & ~load;
        hold_n    = stb ? inSample : hold;
        busy_n    = (state_n != IDLE) | pending_n;
    end

    always_ff @(posedge inClock or posedge inReset) begin
        if (inReset) begin
            state   <= IDLE;
            sh      <= '0;
            cnt     <= '0;
            bitn    <= '0;
            hold    <= '0;
            pending <= 1'b0;
            prev    <= 1'b0;
            armed   <= 1'b0;
            sck     <= 1'b0;
            mosi    <= 1'b0;
            csn     <= 1'b1;
            busy    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_n;
            sh      <= sh_n;
            cnt     <= cnt_n;
            bitn    <= bitn_n;
            hold    <= hold_n;
            pending <= pending_n;
            prev    <= inSampleReady;
            armed   <= armed | ~inSampleReady;
            sck     <= sck_n;
            mosi    <= mosi_n;
            csn     <= csn_n;
            busy    <= busy_n;
            overrun <= overrun_n;
        end
    end

    assign outDacSck  = sck;
    assign outDacMosi = mosi;
    assign outDacCsN  = csn;
    assign outBusy    = busy;
    assign outOverrun = overrun;
endmodule

// File: tb/tb_sample_dac_transmitter.sv
// tb_sample_dac_transmitter: decodes the serial link of two transmitters (CLOCK_DIV 2 and 1) and checks frames against arithmetic expectations.
module tb_sample_dac_transmitter;
    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] smp[2];
    logic        rdy[2];
    logic        sck[2], mosi[2], csn[2], busy[2], ovr[2];

    always #5 clk = ~clk;

    sample_dac_transmitter #(.CLOCK_DIV(2)) dut0 (
        .inClock(clk), .inReset(rst), .inSample(smp[0]), .inSampleReady(rdy[0]),
        .outDacSck(sck[0]), .outDacMosi(mosi[0]), .outDacCsN(csn[0]), .outBusy(busy[0]), .outOverrun(ovr[0])
    );
    sample_dac_transmitter #(.CLOCK_DIV(1)) dut1 (
        .inClock(clk), .inReset(rst), .inSample(smp[1]), .inSampleReady(rdy[1]),
        .outDacSck(sck[1]), .outDacMosi(mosi[1]), .outDacCsN(csn[1]), .outBusy(busy[1]), .outOverrun(ovr[1])
    );

    typedef struct {
        logic [15:0] w;
        int          low;
        int          bits;
        int          gap;
    } frame_t;
    typedef struct {
        logic [11:0] s;
        logic [15:0] w;
    } vec_t;

    frame_t      fq[2][$];
    int          low_c[2], high_c[2], nb[2], viol[2], ovr_c[2], gap_c[2];
    logic [15:0] w_c[2];
    logic        p_csn[2], p_sck[2], p_mosi[2], p_ovr[2];
    int          checks = 0, failures = 0;

    // link decoder: one frame record per CsN-low window; protocol breaches tallied in viol
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (rst) begin
                    low_c[k] = 0; nb[k] = 0; w_c[k] = '0; high_c[k] = -1;
                    p_csn[k] = 1'b1; p_sck[k] = 1'b0; p_mosi[k] = 1'b0; p_ovr[k] = 1'b0;
                    fq[k].delete();
                end else begin
                    if (csn[k] === 1'b0) begin
                        if (p_csn[k]) begin
                            low_c[k] = 0; nb[k] = 0; w_c[k] = '0; gap_c[k] = high_c[k];
                        end
                        low_c[k]++;
                        if (sck[k] && !p_sck[k]) begin
                            w_c[k] = {w_c[k][14:0], mosi[k]};
                            nb[k]++;
                        end
                        if (sck[k] && p_sck[k] && mosi[k] !== p_mosi[k]) viol[k]++;
                        if (busy[k] !== 1'b1) viol[k]++;
                    end else begin
                        if (!p_csn[k]) begin
                            fq[k].push_back('{w_c[k], low_c[k], nb[k], gap_c[k]});
                            high_c[k] = 0;
                        end
                        if (high_c[k] >= 0) high_c[k]++;
                        if (mosi[k] !== 1'b0 || sck[k] !== 1'b0) viol[k]++;
                    end
                    if (ovr[k] === 1'b1) ovr_c[k]++;
                    if (ovr[k] === 1'b1 && p_ovr[k]) viol[k]++;
                    p_csn[k] = csn[k]; p_sck[k] = sck[k]; p_mosi[k] = mosi[k]; p_ovr[k] = ovr[k];
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic strobe(input int k, input logic [11:0] v);
        @(negedge clk);
        smp[k] = v;
        rdy[k] = 1'b1;
        @(negedge clk);
        rdy[k] = 1'b0;
    endtask

    task automatic wait_frames(input int k, input int n);
        int c = 0;
        while (fq[k].size() < n && c < 3000) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic wait_low(input int k);
        int c = 0;
        while (csn[k] !== 1'b0 && c < 500) begin
            @(negedge clk);
            c++;
        end
        chk("csn_went_low", int'(csn[k]), 0);
    endtask

    task automatic idle_wait(input int k);
        int c = 0;
        while (busy[k] !== 1'b0 && c < 500) begin
            @(negedge clk);
            c++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic pop_chk(input int k, input string nm, input logic [15:0] w, input int low, output int gap);
        frame_t f;
        gap = -1;
        wait_frames(k, 1);
        chk({nm, "_present"}, int'(fq[k].size() > 0), 1);
        if (fq[k].size() > 0) begin
            f = fq[k].pop_front();
            chk({nm, "_word"}, int'(f.w), int'(w));
            chk({nm, "_csn_low"}, f.low, low);
            chk({nm, "_bits"}, f.bits, 16);
            gap = f.gap;
        end
    endtask

    function automatic logic [15:0] model(input logic [11:0] s);
        logic [11:0] ob;
        ob = 12'(int'($signed(s)) + 2048);
        return {4'b0011, ob};
    endfunction

    initial begin
        vec_t        tbl[6];
        logic [11:0] s;
        logic [15:0] exp_q[$];
        int          g, o0;
        tbl[0] = '{12'h000, 16'h3800};
        tbl[1] = '{12'h800, 16'h3000};
        tbl[2] = '{12'h7FF, 16'h3FFF};
        tbl[3] = '{12'h001, 16'h3801};
        tbl[4] = '{12'hFFF, 16'h37FF};
        tbl[5] = '{12'h123, 16'h3923};

        rst = 1'b1;
        rdy[0] = 1'b0; rdy[1] = 1'b0; smp[0] = '0; smp[1] = '0;
        repeat (3) @(negedge clk);
        chk("reset_csn", int'(csn[0]), 1);
        chk("reset_sck", int'(sck[0]), 0);
        chk("reset_mosi", int'(mosi[0]), 0);
        chk("reset_busy", int'(busy[0]), 0);
        chk("reset_overrun", int'(ovr[0]), 0);
        chk("reset_csn_div1", int'(csn[1]), 1);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            strobe(0, tbl[i].s);
            pop_chk(0, $sformatf("vec%0d", i), tbl[i].w, 66, g);
            idle_wait(0);
        end

        strobe(0, 12'h800);
        wait_low(0);
        strobe(0, 12'h7FF);
        wait_frames(0, 2);
        pop_chk(0, "b2b_first", 16'h3000, 66, g);
        pop_chk(0, "b2b_second", 16'h3FFF, 66, g);
        chk("b2b_gap", g, 2);
        idle_wait(0);

        o0 = ovr_c[0];
        strobe(0, 12'd1);
        wait_low(0);
        repeat (5) @(negedge clk);
        strobe(0, 12'd2);
        repeat (3) @(negedge clk);
        chk("overrun_after_second", ovr_c[0] - o0, 0);
        strobe(0, 12'd3);
        repeat (3) @(negedge clk);
        chk("overrun_after_third", ovr_c[0] - o0, 1);
        wait_frames(0, 2);
        pop_chk(0, "ovr_first", 16'h3801, 66, g);
        pop_chk(0, "ovr_second", 16'h3803, 66, g);
        idle_wait(0);
        chk("ovr_no_value2", fq[0].size(), 0);

        @(negedge clk);
        smp[0] = 12'h000;
        rdy[0] = 1'b1;
        repeat (100) @(negedge clk);
        rdy[0] = 1'b0;
        idle_wait(0);
        chk("long_strobe_frames", fq[0].size(), 1);
        pop_chk(0, "long_strobe", 16'h3800, 66, g);

        strobe(0, 12'h5A5);
        begin
            int c = 0;
            while (nb[0] != 7 && c < 500) begin
                @(negedge clk);
                c++;
            end
        end
        chk("reset_at_bit7_reached", nb[0], 7);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midreset_csn", int'(csn[0]), 1);
        chk("midreset_sck", int'(sck[0]), 0);
        chk("midreset_mosi", int'(mosi[0]), 0);
        rdy[0] = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (100) @(negedge clk);
        chk("after_reset_no_frame", fq[0].size(), 0);
        chk("after_reset_idle", int'(busy[0]), 0);
        rdy[0] = 1'b0;
        repeat (2) @(negedge clk);
        strobe(0, 12'h7FF);
        pop_chk(0, "post_reset", 16'h3FFF, 66, g);
        idle_wait(0);

        for (int i = 0; i < 10; i++) begin
            s = 12'($urandom);
            strobe(0, s);
            pop_chk(0, $sformatf("rand%0d", i), model(s), 66, g);
            idle_wait(0);
        end

        for (int i = 0; i < 30; i++) begin
            s = 12'($urandom);
            exp_q.push_back(model(s));
            strobe(1, s);
            repeat (33) @(negedge clk);
        end
        wait_frames(1, 30);
        chk("div1_frame_count", fq[1].size(), 30);
        for (int i = 0; i < 30 && fq[1].size() > 0; i++)
            pop_chk(1, $sformatf("div1_%0d", i), exp_q[i], 33, g);
        chk("div1_no_overrun", ovr_c[1], 0);

        chk("protocol_viol_div2", viol[0], 0);
        chk("protocol_viol_div1", viol[1], 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
